// File: rtl/fifo_sync_pkg.sv
// Shared constants and types for the fifo_sync read-side stream controller.
package fifo_sync_pkg;
  localparam int FIFO_RD_LAT   = 1;
  localparam int OUT_BUF_DEPTH = 2;
  localparam int OCC_WIDTH     = 2;

  typedef logic [OCC_WIDTH-1:0] occ_t;
endpackage

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry valid/ready output buffer: push at the tail, pop from the head.
module stream_buf2
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_r [OUT_BUF_DEPTH];
  logic                  head_ptr_r;
  occ_t                  occ_r;
  logic                  valid_r;
  occ_t                  occ_next_s;
  logic                  tail_ptr_s;

  // Next occupancy and tail slot; push never arrives while full.
  always_comb begin
    occ_next_s = occ_r;
    if (push && !pop) begin
      occ_next_s = occ_r + 2'd1;
    end else if (!push && pop) begin
      occ_next_s = occ_r - 2'd1;
    end else begin
      occ_next_s = occ_r;
    end
    tail_ptr_s = head_ptr_r ^ occ_r[0];
  end

  // Storage, head pointer, occupancy and registered valid flag.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      mem_r      <= '{default: '0};
      head_ptr_r <= 1'b0;
      occ_r      <= '0;
      valid_r    <= 1'b0;
    end else begin
      if (push) begin
        mem_r[tail_ptr_s] <= push_data;
      end
      if (pop) begin
        head_ptr_r <= ~head_ptr_r;
      end
      occ_r   <= occ_next_s;
      valid_r <= (occ_next_s != 2'd0);
    end
  end

  assign occ   = occ_r;
  assign valid = valid_r;
  assign head  = mem_r[head_ptr_r];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains fifo_sync through its registered read port and presents a valid/ready stream.
module fifo_rd_stream
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_r_en_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [CNT_WIDTH-1:0]  word_cnt_o,
  output logic                  busy_o
);

  occ_t                 occ_s;
  logic                 valid_s;
  logic                 pop_s;
  logic [2:0]           space_s;
  logic                 rd_issue_s;
  logic                 inflight_r;
  logic [CNT_WIDTH-1:0] cnt_r;

  // A read may issue only if its word is guaranteed a buffer slot on arrival.
  always_comb begin
    pop_s      = valid_s & m_ready_i;
    space_s    = 3'(OUT_BUF_DEPTH) - {1'b0, occ_s} - {2'b00, inflight_r} + {2'b00, pop_s};
    rd_issue_s = resetn_i & en_i & ~fifo_empty_i & (space_s >= 3'd1);
  end

  // In-flight read tracking and delivered-word counter.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      inflight_r <= 1'b0;
      cnt_r      <= '0;
    end else begin
      inflight_r <= rd_issue_s;
      if (pop_s) begin
        cnt_r <= cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .push      (inflight_r),
    .push_data (fifo_data_i),
    .pop       (pop_s),
    .occ       (occ_s),
    .valid     (valid_s),
    .head      (m_data_o)
  );

  assign fifo_r_en_o = rd_issue_s;
  assign m_valid_o   = valid_s;
  assign busy_o      = valid_s | inflight_r;
  assign word_cnt_o  = cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised bench for fifo_rd_stream with an emulated fifo_sync and a word-count reference model.
module tb_fifo_rd_stream;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, en, m_ready, fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_en, fifo_r_en4, m_valid, m_valid4, busy, busy4;
  logic [DW-1:0] m_data, m_data4;
  logic [15:0]   word_cnt;
  logic [3:0]    word_cnt4;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .resetn_i(resetn), .en_i(en), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_r_en_o(fifo_r_en), .m_data_o(m_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .word_cnt_o(word_cnt), .busy_o(busy)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .resetn_i(resetn), .en_i(en), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_r_en_o(fifo_r_en4), .m_data_o(m_data4),
    .m_valid_o(m_valid4), .m_ready_i(m_ready), .word_cnt_o(word_cnt4), .busy_o(busy4)
  );

  // fifo_sync emulation: registered read data, one cycle after r_en
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words read but not yet delivered, and words actually sitting in the buffer
  int            outstanding = 0;
  int            avail = 0;
  int            delivered = 0;
  int            rd_cnt = 0;
  bit            model_on = 1'b0;
  bit            pend = 1'b0;
  bit            pop_e, rd_e;
  logic [DW-1:0] pend_word;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] log_q [$];

  always @(negedge clk) begin
    pop_e = 1'b0;
    rd_e  = 1'b0;
    if (model_on) begin
      pop_e = (avail > 0) && m_ready;
      rd_e  = resetn && en && !fifo_empty && ((2 - outstanding + (pop_e ? 1 : 0)) >= 1);
      chk("r_en", {31'd0, fifo_r_en}, {31'd0, rd_e});
      chk("r_en_w4", {31'd0, fifo_r_en4}, {31'd0, rd_e});
      chk("valid", {31'd0, m_valid}, {31'd0, avail > 0});
      if (avail > 0) chk("data", {24'd0, m_data}, {24'd0, exp_q[0]});
      chk("word_cnt", {16'd0, word_cnt}, {16'd0, delivered[15:0]});
      chk("word_cnt_w4", {28'd0, word_cnt4}, {28'd0, delivered[3:0]});
      chk("busy", {31'd0, busy}, {31'd0, outstanding > 0});
      chk("r_en_vs_empty", {31'd0, fifo_r_en & fifo_empty}, 32'd0);
    end
    if (!resetn) begin
      model_on    = 1'b1;
      outstanding = 0;
      avail       = 0;
      delivered   = 0;
      pend        = 1'b0;
      exp_q.delete();
    end else if (model_on) begin
      if (pop_e) begin
        log_q.push_back(exp_q.pop_front());
        avail--;
        outstanding--;
        delivered++;
      end
      if (pend) begin
        exp_q.push_back(pend_word);
        avail++;
      end
      pend = rd_e;
      if (rd_e) begin
        pend_word = mem[rd_ptr[7:0]];
        outstanding++;
        rd_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [DW-1:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  int base_rd, base_del;

  initial begin
    resetn  = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(1);
    chk("reset_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_cnt", {16'd0, word_cnt}, 32'd0);

    // Stream 16 words at full rate
    for (int i = 1; i <= 16; i++) preload(DW'(i));
    en      = 1'b1;
    m_ready = 1'b1;
    tick(22);
    chk("t1_count", log_q.size(), 32'd16);
    for (int i = 0; i < 16; i++) chk("t1_order", {24'd0, log_q[i]}, i + 1);
    chk("t1_word_cnt", {16'd0, word_cnt}, 32'd16);
    chk("t1_word_cnt_w4", {28'd0, word_cnt4}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Seventeenth pop wraps the 4-bit counter to 1
    preload(8'h11);
    tick(5);
    chk("wrap_word_cnt", {16'd0, word_cnt}, 32'd17);
    chk("wrap_word_cnt_w4", {28'd0, word_cnt4}, 32'd1);

    // Backpressure with 8 words queued
    m_ready = 1'b0;
    base_rd = rd_cnt;
    for (int i = 0; i < 8; i++) preload(DW'($urandom));
    tick(5);
    chk("t2_reads", rd_cnt - base_rd, 32'd2);
    chk("t2_valid", {31'd0, m_valid}, 32'd1);
    chk("t2_r_en", {31'd0, fifo_r_en}, 32'd0);
    m_ready = 1'b1;
    tick(12);
    chk("t2_word_cnt", {16'd0, word_cnt}, 32'd25);

    // Empty FIFO after reset
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    chk("t3_cnt_reset", {16'd0, word_cnt}, 32'd0);
    tick(10);
    chk("t3_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("t3_valid", {31'd0, m_valid}, 32'd0);

    // Throttled consumer
    base_del = delivered;
    for (int i = 0; i < 10; i++) preload(DW'($urandom));
    for (int i = 0; i < 30; i++) begin
      m_ready = i[0];
      tick(1);
    end
    m_ready = 1'b1;
    tick(3);
    chk("t4_word_cnt", {16'd0, word_cnt}, base_del + 10);

    // en_i drops right after a read issues
    en = 1'b0;
    for (int i = 0; i < 6; i++) preload(DW'($urandom));
    base_rd  = rd_cnt;
    base_del = delivered;
    en = 1'b1;
    tick(1);
    en = 1'b0;
    tick(8);
    chk("t5_reads", rd_cnt - base_rd, 32'd1);
    chk("t5_word_cnt", {16'd0, word_cnt}, base_del + 1);

    // Reset with a full buffer
    en      = 1'b1;
    m_ready = 1'b0;
    tick(4);
    chk("t6_valid", {31'd0, m_valid}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    tick(1);
    chk("t6_valid_rst", {31'd0, m_valid}, 32'd0);
    chk("t6_cnt_rst", {16'd0, word_cnt}, 32'd0);
    chk("t6_r_en_rst", {31'd0, fifo_r_en}, 32'd0);
    resetn  = 1'b1;
    m_ready = 1'b1;
    tick(10);

    // Random enable and ready
    for (int i = 0; i < 20; i++) preload(DW'($urandom));
    for (int i = 0; i < 80; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) == 1;
      tick(1);
    end
    en      = 1'b1;
    m_ready = 1'b1;
    tick(30);
    chk("rand_drained", {31'd0, fifo_empty}, 32'd1);
    chk("rand_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
